// File: rtl/freq_synthesizer.sv
// Emits freq_act evenly spread single-cycle strobes per PERIOD-cycle window.
// stb/window_stb are registered (one cycle after cnt/sum); enable=0 freezes state and suppresses both strobes.
module freq_synthesizer #(
    parameter int PERIOD = 1000,
    parameter int W      = $clog2(PERIOD + 1)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    input  logic         clear,
    input  logic [W-1:0] frequency,
    output logic         stb,
    output logic         window_stb,
    output logic [W-1:0] frequency_active
);
    localparam int CW = $clog2(PERIOD);
    localparam int SW = $clog2(2 * PERIOD);
    localparam logic [CW-1:0] LAST  = CW'(PERIOD - 1);
    localparam logic [W-1:0]  PER_W = W'(PERIOD);
    localparam logic [SW-1:0] PER_S = SW'(PERIOD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] acc_q, acc_d;
    logic [W-1:0]  fa_q, fa_d;
    logic          stb_q, stb_d;
    logic          wstb_q, wstb_d;
    logic [W-1:0]  freq_sat;
    logic [SW-1:0] sum;

    always_comb begin
        freq_sat = (frequency > PER_W) ? PER_W : frequency;
        sum      = SW'(acc_q) + SW'(fa_q);
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        fa_d     = fa_q;
        stb_d    = 1'b0;
        wstb_d   = 1'b0;
        if (clear) begin
            cnt_d = '0;
            acc_d = '0;
            fa_d  = freq_sat;
        end else if (enable) begin
            if (sum >= PER_S) begin
                acc_d = CW'(sum - PER_S);
                stb_d = 1'b1;
            end else begin
                acc_d = CW'(sum);
            end
            wstb_d = (cnt_q == LAST);
            // The rate only changes here, where acc is guaranteed back at zero.
            if (cnt_q == LAST) begin
                cnt_d = '0;
                fa_d  = freq_sat;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            fa_q   <= '0;
            stb_q  <= 1'b0;
            wstb_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            fa_q   <= fa_d;
            stb_q  <= stb_d;
            wstb_q <= wstb_d;
        end
    end

    assign stb              = stb_q;
    assign window_stb       = wstb_q;
    assign frequency_active = fa_q;
endmodule

// File: tb/tb_freq_synthesizer.sv
// Bench for freq_synthesizer with PERIOD=10 and PERIOD=1000 instances.
module tb_freq_synthesizer;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       en10, clr10, en1k, clr1k;
    logic [3:0] f10, fa10;
    logic [9:0] f1k, fa1k;
    logic       stb10, w10, stb1k, w1k;

    always #5 clk = ~clk;

    freq_synthesizer #(.PERIOD(10)) u_dut10 (
        .clk(clk), .reset_n(reset_n), .enable(en10), .clear(clr10),
        .frequency(f10), .stb(stb10), .window_stb(w10), .frequency_active(fa10)
    );

    freq_synthesizer #(.PERIOD(1000)) u_dut1k (
        .clk(clk), .reset_n(reset_n), .enable(en1k), .clear(clr1k),
        .frequency(f1k), .stb(stb1k), .window_stb(w1k), .frequency_active(fa1k)
    );

    typedef struct {
        bit s;
        bit w;
        int fa;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   sel1k;
    int   m_cnt, m_fa;
    int   a_stb, a_w, a_fa;
    int   run_stb, win_total;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference: within a window, cycle k strobes iff floor((k+1)f/P) > floor(kf/P).
    task automatic tick(input bit en, input bit clr, input int f);
        int   p;
        int   fs;
        exp_t e;
        p     = sel1k ? 1000 : 10;
        fs    = (f > p) ? p : f;
        en10  = !sel1k && en;
        clr10 = !sel1k && clr;
        en1k  = sel1k && en;
        clr1k = sel1k && clr;
        f10   = 4'(f);
        f1k   = 10'(f);
        e.s = 1'b0;
        e.w = 1'b0;
        if (clr) begin
            m_cnt = 0;
            m_fa  = fs;
        end else if (en) begin
            e.s = (((m_cnt + 1) * m_fa) / p) > ((m_cnt * m_fa) / p);
            e.w = (m_cnt == p - 1);
            if (m_cnt == p - 1) begin
                m_cnt = 0;
                m_fa  = fs;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        e.fa = m_fa;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        a_stb = sel1k ? int'(stb1k) : int'(stb10);
        a_w   = sel1k ? int'(w1k)   : int'(w10);
        a_fa  = sel1k ? int'(fa1k)  : int'(fa10);
        if (sb.size() == 0) begin
            check_eq("sb_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            check_eq("stb", a_stb, int'(e.s));
            check_eq("window_stb", a_w, int'(e.w));
            check_eq("freq_active", a_fa, e.fa);
        end
        if (clr) begin
            run_stb = 0;
        end else begin
            if (a_stb != 0) run_stb++;
            if (a_w != 0) begin
                win_total = run_stb;
                run_stb   = 0;
            end
        end
    endtask

    initial begin
        int wn;
        int last;
        int cyc;
        reset_n = 1'b0;
        en10 = 0; clr10 = 0; en1k = 0; clr1k = 0;
        f10 = '0; f1k = '0;
        sel1k = 0; m_cnt = 0; m_fa = 0; run_stb = 0; win_total = 0;
        #12;
        check_eq("rst_stb10", int'(stb10), 0);
        check_eq("rst_w10", int'(w10), 0);
        check_eq("rst_fa10", int'(fa10), 0);
        check_eq("rst_stb1k", int'(stb1k), 0);
        check_eq("rst_fa1k", int'(fa1k), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic rate 3/10 over two windows
        tick(0, 1, 3);
        for (int i = 1; i <= 20; i++) begin
            tick(1, 0, 3);
            if (i == 4 || i == 7 || i == 10) check_eq("f3_pos", a_stb, 1);
            if (a_w != 0) check_eq("f3_win", win_total, 3);
        end

        // Mid-window rate change is deferred to the wrap
        tick(0, 1, 3);
        for (int i = 0; i < 4; i++) tick(1, 0, 3);
        wn = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1, 0, 7);
            if (wn == 0 && a_w == 0) check_eq("chg_fa_hold", a_fa, 3);
            if (a_w != 0) begin
                wn++;
                check_eq(wn == 1 ? "chg_win1" : "chg_win2", win_total, wn == 1 ? 3 : 7);
                if (wn == 1) check_eq("chg_fa_new", a_fa, 7);
            end
        end
        check_eq("chg_nwin", wn, 2);

        // Freeze for 5 cycles at cnt=5
        tick(0, 1, 3);
        wn = 0;
        for (int i = 1; i <= 15; i++) begin
            tick((i <= 5 || i > 10), 0, 3);
            if (i > 5 && i <= 10) check_eq("frz_quiet", a_stb + a_w, 0);
            if (a_w != 0) begin
                wn = i;
                check_eq("frz_win", win_total, 3);
            end
        end
        check_eq("frz_wpos", wn, 15);

        // Boundary rates
        tick(0, 1, 10);
        for (int i = 0; i < 20; i++) tick(1, 0, 10);
        tick(0, 1, 0);
        for (int i = 0; i < 20; i++) tick(1, 0, 0);
        tick(0, 1, 15);
        check_eq("sat_fa", a_fa, 10);
        for (int i = 0; i < 20; i++) begin
            tick(1, 0, 15);
            check_eq("sat_stb", a_stb, 1);
        end

        // Asynchronous reset mid-window
        tick(0, 1, 10);
        for (int i = 0; i < 3; i++) tick(1, 0, 10);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_stb", int'(stb10), 0);
        check_eq("arst_w", int'(w10), 0);
        check_eq("arst_fa", int'(fa10), 0);
        m_cnt = 0; m_fa = 0; run_stb = 0;
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        wn = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1, 0, 5);
            if (a_w != 0) begin
                wn++;
                check_eq(wn == 1 ? "arst_win1" : "arst_win2", win_total, wn == 1 ? 0 : 5);
            end
        end

        // PERIOD=1000, rate 37 over 20 windows
        sel1k = 1;
        tick(0, 1, 37);
        last = -1;
        wn = 0;
        for (cyc = 0; cyc < 20000; cyc++) begin
            tick(1, 0, 37);
            if (a_stb != 0) begin
                if (last >= 0) check_eq("gap_27_28", int'((cyc - last) == 27 || (cyc - last) == 28), 1);
                last = cyc;
            end
            if (a_w != 0) begin
                wn++;
                check_eq("win37", win_total, 37);
            end
        end
        check_eq("n_win37", wn, 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
